// File: rtl/wb_tt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// wb_tt_ctrl_pkg : shared register map, FSM states and STATUS layout
// Revision       : 1.0
// ============================================================================
package wb_tt_ctrl_pkg;

    localparam logic [3:0] OFF_SEL    = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_FW     = 4'h8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_ENA     = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_IDX_LSB = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_LO  = 3'd1,
        RST_GAP = 3'd2,
        INC_HI  = 3'd3,
        INC_LO  = 3'd4,
        DONE    = 3'd5
    } tt_state_e;

endpackage
`default_nettype wire

// File: rtl/tt_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// tt_ctrl_fsm : plays out reset pulse + N increment pulses on the mux pins
// Revision    : 1.0
// ============================================================================
module tt_ctrl_fsm
    import wb_tt_ctrl_pkg::*;
#(
    parameter int IDX_W     = 9,
    parameter int RST_CYC   = 8,
    parameter int PULSE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] index,
    output logic             sel_rst_n,
    output logic             sel_inc,
    output logic             busy,
    output logic             done
);

    localparam int MAX_CYC = (RST_CYC > PULSE_CYC) ? RST_CYC : PULSE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);

    tt_state_e        state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [IDX_W-1:0] remaining, remaining_nx;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Pin levels are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
            sel_rst_n <= 1'b1;
            sel_inc   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            remaining <= remaining_nx;
            sel_rst_n <= (state_nx != RST_LO);
            sel_inc   <= (state_nx == INC_HI);
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + CW'(1);
        remaining_nx = remaining;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx     = RST_LO;
                    remaining_nx = index;
                end
            end
            RST_LO: begin
                if (cnt == RST_LAST) begin
                    state_nx = RST_GAP;
                    cnt_nx   = '0;
                end
            end
            RST_GAP: begin
                if (cnt == RST_LAST) begin
                    state_nx = (remaining != '0) ? INC_HI : DONE;
                    cnt_nx   = '0;
                end
            end
            INC_HI: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = INC_LO;
                    cnt_nx   = '0;
                end
            end
            INC_LO: begin
                if (cnt == PULSE_LAST) begin
                    remaining_nx = remaining - IDX_W'(1);
                    state_nx     = (remaining > IDX_W'(1)) ? INC_HI : DONE;
                    cnt_nx       = '0;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_tt_ctrl_seq.sv
`default_nettype none
// ============================================================================
// wb_tt_ctrl_seq : Wishbone slave driving the Tiny Tapeout mux control pins
// Revision       : 1.0
// ============================================================================
module wb_tt_ctrl_seq
    import wb_tt_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IDX_W     = 9,
    parameter int          RST_CYC   = 8,
    parameter int          PULSE_CYC = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ctrl_sel_rst_n,
    output logic        ctrl_sel_inc,
    output logic        ctrl_ena,
    output logic        fw_ready
);

    logic [3:0]       off;
    logic             hit, req, wr_full, sel_wr, fw_wr, start;
    logic             busy, done, err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      status, rdata;
    logic             unused_dat;

    assign off     = wbs_adr_i[3:0];
    assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & hit;
    assign wr_full = req & wbs_we_i & (wbs_sel_i == 4'hF);
    assign sel_wr  = wr_full & (off == OFF_SEL);
    assign fw_wr   = wr_full & (off == OFF_FW);
    // A SEL write only launches a sequence from IDLE; otherwise it just flags err.
    assign start   = sel_wr & ~busy;

    assign unused_dat = &{1'b0, wbs_dat_i[31:IDX_W]};

    always_comb begin
        status                          = '0;
        status[STAT_BUSY]               = busy;
        status[STAT_ENA]                = ctrl_ena;
        status[STAT_ERR]                = err;
        status[STAT_IDX_LSB +: IDX_W]   = idx;
        rdata                           = '0;
        case (off)
            OFF_STATUS: rdata = status;
            OFF_FW:     rdata = {31'b0, fw_ready};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            fw_ready  <= 1'b0;
            ctrl_ena  <= 1'b0;
            idx       <= '0;
            err       <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            if (fw_wr) begin
                fw_ready <= wbs_dat_i[0];
            end
            if (sel_wr) begin
                if (busy) begin
                    err <= 1'b1;
                end else begin
                    err <= 1'b0;
                    idx <= wbs_dat_i[IDX_W-1:0];
                end
            end
            if (start) begin
                ctrl_ena <= 1'b0;
            end else if (done) begin
                ctrl_ena <= 1'b1;
            end
        end
    end

    tt_ctrl_fsm #(
        .IDX_W     (IDX_W),
        .RST_CYC   (RST_CYC),
        .PULSE_CYC (PULSE_CYC)
    ) u_fsm (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .start     (start),
        .index     (wbs_dat_i[IDX_W-1:0]),
        .sel_rst_n (ctrl_sel_rst_n),
        .sel_inc   (ctrl_sel_inc),
        .busy      (busy),
        .done      (done)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_tt_ctrl_seq.sv
`default_nettype none
// ============================================================================
// tb_wb_tt_ctrl_seq : randomized bench against a timeline model of the pins
// Revision          : 1.0
// ============================================================================
module tb_wb_tt_ctrl_seq;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          IDX_W = 9;
    localparam int          R     = 4;
    localparam int          P     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        sel_rst_n, inc, ena, fw;

    int cyc_cnt   = 0;
    bit have_seq  = 1'b0;
    int t0        = 0;
    int seq_n     = 0;
    bit fw_model  = 1'b0;
    bit err_model = 1'b0;
    int idx_model = 0;
    int errors    = 0;
    int checks    = 0;

    wb_tt_ctrl_seq #(
        .BASE_ADDR (BASE),
        .IDX_W     (IDX_W),
        .RST_CYC   (R),
        .PULSE_CYC (P)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_stb_i      (stb),
        .wbs_cyc_i      (cyc),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (dat),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (dat_o),
        .ctrl_sel_rst_n (sel_rst_n),
        .ctrl_sel_inc   (inc),
        .ctrl_ena       (ena),
        .fw_ready       (fw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Timeline model: d = clocks since the edge that accepted the SEL write.
    function automatic int seq_len();
        return 2 * R + 2 * P * seq_n;
    endfunction
    function automatic bit m_busy(input int c);
        return have_seq && (c - t0) >= 0 && (c - t0) <= seq_len();
    endfunction
    function automatic bit m_rst_n(input int c);
        return !(have_seq && (c - t0) >= 0 && (c - t0) < R);
    endfunction
    function automatic bit m_inc(input int c);
        int d;
        d = c - t0;
        return have_seq && d >= 2 * R && d < seq_len() && ((d - 2 * R) % (2 * P)) < P;
    endfunction
    function automatic bit m_ena(input int c);
        return have_seq && (c - t0) > seq_len();
    endfunction
    function automatic logic [31:0] status_word(input int c);
        return 32'(idx_model) * 32'h1_0000 + 32'(err_model) * 4 +
               32'(m_ena(c)) * 2 + 32'(m_busy(c));
    endfunction

    always @(negedge clk) begin
        check_val("sel_rst_n", 32'(sel_rst_n), 32'(m_rst_n(cyc_cnt)));
        check_val("sel_inc",   32'(inc),       32'(m_inc(cyc_cnt)));
        check_val("ena",       32'(ena),       32'(m_ena(cyc_cnt)));
        check_val("fw_ready",  32'(fw),        32'(fw_model));
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int          c;
        logic        in_win;
        logic [3:0]  o;
        logic [31:0] exp_rd;
        bit          busy_now;
        @(negedge clk);
        c        = cyc_cnt;
        in_win   = (a[31:4] == BASE[31:4]);
        o        = a[3:0];
        busy_now = m_busy(c);
        exp_rd   = '0;
        if (o == 4'h4)      exp_rd = status_word(c);
        else if (o == 4'h8) exp_rd = 32'(fw_model);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        check_val("ack_pre", 32'(ack), 32'd0);
        @(posedge clk); #1;
        rd = dat_o;
        if (!in_win) begin
            check_val("ack_oow", 32'(ack), 32'd0);
            repeat (2) begin
                @(posedge clk); #1;
                check_val("ack_oow", 32'(ack), 32'd0);
            end
            stb = 1'b0; cyc = 1'b0; we = 1'b0;
        end else begin
            check_val("ack", 32'(ack), 32'd1);
            if (!w) check_val("rdata", dat_o, exp_rd);
            else if (s == 4'hF) begin
                if (o == 4'h0) begin
                    if (busy_now) err_model = 1'b1;
                    else begin
                        err_model = 1'b0;
                        idx_model = int'(d[IDX_W-1:0]);
                        seq_n     = idx_model;
                        t0        = c + 1;
                        have_seq  = 1'b1;
                    end
                end else if (o == 4'h8) begin
                    fw_model = d[0];
                end
            end
            stb = 1'b0; cyc = 1'b0; we = 1'b0;
            @(posedge clk); #1;
            check_val("ack_drop", 32'(ack), 32'd0);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_busy(cyc_cnt) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst       = 1'b1;
        have_seq  = 1'b0;
        fw_model  = 1'b0;
        err_model = 1'b0;
        idx_model = 0;
        seq_n     = 0;
        #1;
        check_val("rst_sel_rst_n", 32'(sel_rst_n), 32'd1);
        check_val("rst_inc",       32'(inc),       32'd0);
        check_val("rst_ena",       32'(ena),       32'd0);
        check_val("rst_fw",        32'(fw),        32'd0);
        check_val("rst_ack",       32'(ack),       32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          op;
        int          guard;
        logic [31:0] r, rd, a;
        logic [3:0]  o, s;

        repeat (2) @(negedge clk);
        check_val("init_ack", 32'(ack), 32'd0);
        check_val("init_dat", dat_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);

        // Index 3: 21 clocks from sel_rst_n fall to ena rise.
        wb_xfer(1'b1, BASE, 32'd3, 4'hF, rd);
        wait_idle();
        wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);
        check_val("status_idx3", rd, 32'h0003_0002);

        wb_xfer(1'b1, BASE, 32'd0, 4'hF, rd);
        wait_idle();

        // Busy SEL write is dropped and flagged; FW write runs alongside.
        wb_xfer(1'b1, BASE, 32'd3, 4'hF, rd);
        wb_xfer(1'b1, BASE, 32'd5, 4'hF, rd);
        wb_xfer(1'b1, BASE + 32'h8, 32'd1, 4'hF, rd);
        wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);
        check_val("status_err", rd & 32'h4, 32'h4);
        wb_xfer(1'b0, BASE + 32'h8, '0, 4'hF, rd);
        wait_idle();
        wb_xfer(1'b1, BASE, 32'd1, 4'hF, rd);
        wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);
        wait_idle();

        for (int i = 0; i < 120; i++) begin
            op = int'($urandom_range(0, 7));
            r  = $urandom();
            case (op)
                0, 1: wb_xfer(1'b1, BASE, (r & 32'hFFFF_FE00) | 32'($urandom_range(0, 6)), 4'hF, rd);
                2:    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);
                3:    wb_xfer(1'b1, BASE + 32'h8, r, 4'hF, rd);
                4:    wb_xfer(1'b0, BASE + 32'h8, '0, 4'hF, rd);
                5: begin
                    o = r[3:0];
                    if (o == 4'h0 || o == 4'h4 || o == 4'h8) o = 4'hC;
                    wb_xfer(r[4], BASE | 32'(o), r, 4'hF, rd);
                end
                6: begin
                    s = r[9:6];
                    if (s == 4'hF) s = 4'h7;
                    wb_xfer(1'b1, r[5] ? BASE : BASE + 32'h8, r, s, rd);
                end
                default: begin
                    a = BASE + 32'h10 + (r & 32'h0000_0FF0);
                    wb_xfer(r[4], a, r, 4'hF, rd);
                end
            endcase
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle();

        // All-ones index: full 511 pulses, counter must not wrap.
        wb_xfer(1'b1, BASE, 32'h0000_01FF, 4'hF, rd);
        wait_idle();
        wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);

        // Asynchronous reset while inc is high, then a clean sequence.
        wb_xfer(1'b1, BASE + 32'h8, 32'd1, 4'hF, rd);
        wb_xfer(1'b1, BASE, 32'd4, 4'hF, rd);
        guard = 0;
        while ((cyc_cnt - t0) < 2 * R && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_val("inc_before_rst", 32'(inc), 32'd1);
        do_reset();
        wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);
        check_val("status_after_rst", rd, 32'd0);
        wb_xfer(1'b1, BASE, 32'd2, 4'hF, rd);
        wait_idle();
        wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, rd);
        check_val("status_idx2", rd, 32'h0002_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
